// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Summary  : Single-clock FIFO with occupancy count, thresholds, sticky error
//            flags, synchronous flush and show-ahead or registered read data.
// Revision : 1.0
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter bit FWFT      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              write_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_en,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] c_depth_cnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] c_af_lvl    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_ae_lvl    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status is decoded from the registered count only, so a full FIFO stays
    // full for the whole cycle regardless of a concurrent read.
    assign w_full   = (count_q == c_depth_cnt);
    assign w_empty  = (count_q == '0);
    assign w_wr_acc = write_en && !w_full && !clr;
    assign w_rd_acc = read_en && !w_empty && !clr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (w_wr_acc && !w_rd_acc) begin
                count_d = count_q + 1'b1;
            end else if (w_rd_acc && !w_wr_acc) begin
                count_d = count_q - 1'b1;
            end
            if (write_en && w_full) begin
                overflow_d = 1'b1;
            end
            if (read_en && w_empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = w_empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (clr) begin
                    dout_d = '0;
                end else if (w_rd_acc) begin
                    dout_d = mem_q[rd_ptr_q];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (count_q >= c_af_lvl);
    assign almost_empty = (count_q <= c_ae_lvl);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Summary  : Queue-model bench for a 4-deep show-ahead FIFO and a 16-deep
//            registered-read FIFO sharing one clock and reset.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DEPTH=4, show-ahead, AF=3, AE=1
    logic       clr_a, we_a, re_a;
    logic [7:0] din_a, dout_a;
    logic       full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [2:0] cnt_a;

    // Instance B: DEPTH=16, registered read, AF=14, AE=1
    logic       clr_b, we_b, re_b;
    logic [7:0] din_b, dout_b;
    logic       full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [4:0] cnt_b;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b1)
    ) u_a (
        .clk(clk), .rst(rst), .clr(clr_a), .write_en(we_a), .data_in(din_a),
        .read_en(re_a), .data_out(dout_a), .full(full_a), .empty(empty_a),
        .almost_full(af_a), .almost_empty(ae_a), .count(cnt_a),
        .overflow(ovf_a), .underflow(udf_a)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(1), .FWFT(1'b0)
    ) u_b (
        .clk(clk), .rst(rst), .clr(clr_b), .write_en(we_b), .data_in(din_b),
        .read_en(re_b), .data_out(dout_b), .full(full_b), .empty(empty_b),
        .almost_full(af_b), .almost_empty(ae_b), .count(cnt_b),
        .overflow(ovf_b), .underflow(udf_b)
    );

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_ovf_a, m_udf_a, m_ovf_b, m_udf_b;
    logic [7:0] m_dout_b;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag);
        int n = qa.size();
        chk({tag, ".a.count"}, 32'(cnt_a), 32'(n));
        chk({tag, ".a.full"}, 32'(full_a), 32'(n == 4));
        chk({tag, ".a.empty"}, 32'(empty_a), 32'(n == 0));
        chk({tag, ".a.afull"}, 32'(af_a), 32'(n >= 3));
        chk({tag, ".a.aempty"}, 32'(ae_a), 32'(n <= 1));
        chk({tag, ".a.ovf"}, 32'(ovf_a), 32'(m_ovf_a));
        chk({tag, ".a.udf"}, 32'(udf_a), 32'(m_udf_a));
        chk({tag, ".a.dout"}, 32'(dout_a), (n > 0) ? 32'(qa[0]) : 32'h0);
    endtask

    task automatic check_b(input string tag);
        int n = qb.size();
        chk({tag, ".b.count"}, 32'(cnt_b), 32'(n));
        chk({tag, ".b.full"}, 32'(full_b), 32'(n == 16));
        chk({tag, ".b.empty"}, 32'(empty_b), 32'(n == 0));
        chk({tag, ".b.afull"}, 32'(af_b), 32'(n >= 14));
        chk({tag, ".b.aempty"}, 32'(ae_b), 32'(n <= 1));
        chk({tag, ".b.ovf"}, 32'(ovf_b), 32'(m_ovf_b));
        chk({tag, ".b.udf"}, 32'(udf_b), 32'(m_udf_b));
        chk({tag, ".b.dout"}, 32'(dout_b), 32'(m_dout_b));
    endtask

    task automatic step_a(input bit we, input logic [7:0] d, input bit re, input bit cl,
                          input string tag);
        bit was_full  = (qa.size() == 4);
        bit was_empty = (qa.size() == 0);
        we_a = we; din_a = d; re_a = re; clr_a = cl;
        @(posedge clk);
        #1;
        if (cl) begin
            qa.delete();
            m_ovf_a = 1'b0;
            m_udf_a = 1'b0;
        end else begin
            if (we && was_full)  m_ovf_a = 1'b1;
            if (re && was_empty) m_udf_a = 1'b1;
            if (re && !was_empty) void'(qa.pop_front());
            if (we && !was_full)  qa.push_back(d);
        end
        we_a = 1'b0; re_a = 1'b0; clr_a = 1'b0;
        check_a(tag);
    endtask

    task automatic step_b(input bit we, input logic [7:0] d, input bit re, input bit cl,
                          input string tag);
        bit was_full  = (qb.size() == 16);
        bit was_empty = (qb.size() == 0);
        we_b = we; din_b = d; re_b = re; clr_b = cl;
        @(posedge clk);
        #1;
        if (cl) begin
            qb.delete();
            m_ovf_b  = 1'b0;
            m_udf_b  = 1'b0;
            m_dout_b = 8'h00;
        end else begin
            if (we && was_full)  m_ovf_b = 1'b1;
            if (re && was_empty) m_udf_b = 1'b1;
            if (re && !was_empty) m_dout_b = qb.pop_front();
            if (we && !was_full)  qb.push_back(d);
        end
        we_b = 1'b0; re_b = 1'b0; clr_b = 1'b0;
        check_b(tag);
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_ovf_a = 1'b0; m_udf_a = 1'b0;
        m_ovf_b = 1'b0; m_udf_b = 1'b0;
        m_dout_b = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        clr_a = 1'b0; we_a = 1'b0; re_a = 1'b0; din_a = 8'h00;
        clr_b = 1'b0; we_b = 1'b0; re_b = 1'b0; din_b = 8'h00;
        model_reset();
        #22;
        check_a("reset");
        check_b("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill A, then attempt a write while full
        step_a(1, 8'h11, 0, 0, "fill0");
        step_a(1, 8'h22, 0, 0, "fill1");
        step_a(1, 8'h33, 0, 0, "fill2");
        step_a(1, 8'h44, 0, 0, "fill3");
        chk("a_full_lit", 32'(full_a), 32'h1);
        chk("a_head_lit", 32'(dout_a), 32'h11);
        step_a(1, 8'h55, 0, 0, "ovf");
        chk("a_ovf_lit", 32'(ovf_a), 32'h1);
        chk("a_ovf_cnt", 32'(cnt_a), 32'h4);
        for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1, 0, "drain");
        chk("a_drain_empty", 32'(empty_a), 32'h1);
        chk("a_drain_dout", 32'(dout_a), 32'h0);
        chk("a_ovf_sticky", 32'(ovf_a), 32'h1);
        step_a(0, 8'h00, 0, 1, "clr");
        chk("a_clr_ovf", 32'(ovf_a), 32'h0);

        // Underflow then wrapping write/read pairs
        step_a(0, 8'h00, 1, 0, "udf");
        chk("a_udf_lit", 32'(udf_a), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step_a(1, 8'(i), 0, 0, "pair_w");
            chk("a_pair_head", 32'(dout_a), 32'(i));
            step_a(0, 8'h00, 1, 0, "pair_r");
        end

        // Concurrent access at count 2, then at full
        step_a(1, 8'hA0, 0, 0, "sim_w0");
        step_a(1, 8'hA1, 0, 0, "sim_w1");
        for (int i = 0; i < 3; i++) step_a(1, 8'hB0 + 8'(i), 1, 0, "sim_rw");
        chk("a_sim_cnt", 32'(cnt_a), 32'h2);
        step_a(1, 8'hC0, 0, 0, "sim_f0");
        step_a(1, 8'hC1, 0, 0, "sim_f1");
        step_a(1, 8'hC2, 1, 0, "full_rw");
        chk("a_fullrw_cnt", 32'(cnt_a), 32'h3);
        chk("a_fullrw_ovf", 32'(ovf_a), 32'h1);

        // B: fill to full through both thresholds, then drain
        step_b(0, 8'h00, 0, 1, "b_clr");
        for (int i = 0; i < 17; i++) step_b(1, 8'h40 + 8'(i), 0, 0, "b_fill");
        chk("b_full_lit", 32'(full_b), 32'h1);
        for (int i = 0; i < 16; i++) step_b(0, 8'h00, 1, 0, "b_drain");

        // B registered read: data appears after the accepting edge and holds
        step_b(1, 8'hA5, 0, 0, "b_wa5");
        step_b(0, 8'h00, 1, 0, "b_ra5");
        chk("b_a5_lit", 32'(dout_b), 32'hA5);
        for (int i = 0; i < 3; i++) step_b(0, 8'h00, 0, 0, "b_hold");
        chk("b_hold_lit", 32'(dout_b), 32'hA5);

        // Asynchronous reset with words queued
        step_b(1, 8'h01, 0, 0, "b_q");
        step_b(1, 8'h02, 0, 0, "b_q");
        step_b(1, 8'h03, 0, 0, "b_q");
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("b_rst_cnt", 32'(cnt_b), 32'h0);
        chk("b_rst_empty", 32'(empty_b), 32'h1);
        chk("b_rst_dout", 32'(dout_b), 32'h0);
        check_a("midrst");
        @(negedge clk) rst = 1'b0;
        step_b(1, 8'h3C, 0, 0, "b_post_w");
        step_b(0, 8'h00, 1, 0, "b_post_r");
        chk("b_post_lit", 32'(dout_b), 32'h3C);

        // Randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 400; i++) begin
            int pw = ((i / 40) % 2 == 0) ? 75 : 25;
            step_a($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
                   $urandom_range(0, 63) == 0, "rnd");
        end
        for (int i = 0; i < 600; i++) begin
            int pw = ((i / 60) % 2 == 0) ? 80 : 20;
            step_b($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw),
                   $urandom_range(0, 99) == 0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
